// File: rtl/onchip_ram_pkg.sv
// onchip_ram_pkg: shared geometry, error pattern and read-tag type for the on-chip RAM arbiter
package onchip_ram_pkg;
  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DEPTH = 10240;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_BE_W = 4;
  localparam logic [RAM_DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;
  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } rd_tag_t;
endpackage

// File: rtl/onchip_ram_arbiter_if.sv
// onchip_ram_arbiter_if: Avalon-MM requester bus between one master and the arbiter
interface onchip_ram_arbiter_if;
  import onchip_ram_pkg::*;
  logic [RAM_ADDR_W-1:0] address;
  logic [RAM_BE_W-1:0] byteenable;
  logic read;
  logic write;
  logic [RAM_DATA_W-1:0] writedata;
  logic waitrequest;
  logic readdatavalid;
  logic [RAM_DATA_W-1:0] readdata;
  modport master(output address, byteenable, read, write, writedata, input waitrequest, readdatavalid, readdata);
  modport slave(input address, byteenable, read, write, writedata, output waitrequest, readdatavalid, readdata);
endinterface

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the requester that was not granted last
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);
  logic last_q, last_d;
  always_comb begin
    grant_o[0] = req_i[0] & (~req_i[1] | last_q);
    grant_o[1] = req_i[1] & (~req_i[0] | ~last_q);
    last_d = grant_o[1] ? 1'b1 : grant_o[0] ? 1'b0 : last_q;
  end
  always_ff @(posedge clk) last_q <= reset ? 1'b1 : last_d;
endmodule

// File: rtl/onchip_ram_arbiter.sv
// onchip_ram_arbiter: round-robin two-master front end for the single-port on-chip RAM with range filtering
module onchip_ram_arbiter
  import onchip_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH = RAM_DEPTH,
  parameter logic [RAM_DATA_W-1:0] ERR_DATA = onchip_ram_pkg::ERR_DATA
) (
  input  logic                  clk,
  input  logic                  reset,
  onchip_ram_arbiter_if.slave   m0,
  onchip_ram_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [RAM_BE_W-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [RAM_DATA_W-1:0] ram_writedata,
  output logic                  ram_clken,
  input  logic [RAM_DATA_W-1:0] ram_readdata,
  output logic [7:0]            err_count
);
  logic [1:0] req, gnt;
  logic any, sel, wr, oor, rv0, rv1;
  logic [ADDR_W-1:0] addr;
  logic [RAM_DATA_W-1:0] rdata;
  rd_tag_t tag_q, tag_d;
  logic [7:0] err_q, err_d;
  assign req = reset ? 2'b00 : {m1.read | m1.write, m0.read | m0.write};
  rr_arb2 u_arb (.clk(clk), .reset(reset), .req_i(req), .grant_o(gnt));
  // A simultaneous read+write on one requester is taken as a write, so wr alone decides the access type.
  always_comb begin
    any = |gnt;
    sel = gnt[1];
    addr = sel ? m1.address : m0.address;
    wr = sel ? m1.write : m0.write;
    oor = any & (32'(addr) >= 32'(DEPTH));
    ram_chipselect = any & ~oor;
    ram_write = ram_chipselect & wr;
    ram_address = ram_chipselect ? addr : '0;
    ram_byteenable = ram_chipselect ? (sel ? m1.byteenable : m0.byteenable) : '0;
    ram_writedata = ram_chipselect ? (sel ? m1.writedata : m0.writedata) : '0;
    ram_clken = ~reset;
    tag_d = '{valid: any & ~wr, owner: sel, err: oor};
    err_d = (oor && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    err_count = reset ? '0 : err_q;
    m0.waitrequest = reset | (req[0] & ~gnt[0]);
    m1.waitrequest = reset | (req[1] & ~gnt[1]);
    rv0 = ~reset & tag_q.valid & ~tag_q.owner;
    rv1 = ~reset & tag_q.valid & tag_q.owner;
    rdata = tag_q.err ? ERR_DATA : ram_readdata;
    m0.readdatavalid = rv0;
    m1.readdatavalid = rv1;
    m0.readdata = rv0 ? rdata : '0;
    m1.readdata = rv1 ? rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
      err_q <= '0;
    end else begin
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb_onchip_ram_arbiter: directed checks of arbitration, read routing, byte lanes, range errors and reset
module tb_onchip_ram_arbiter;
  import onchip_ram_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [RAM_ADDR_W-1:0] ram_address;
  logic [RAM_BE_W-1:0] ram_byteenable;
  logic ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
  logic [7:0] err_count;
  logic [31:0] mem [RAM_DEPTH];
  int checks = 0;
  int errors = 0;
  onchip_ram_arbiter_if m0_if ();
  onchip_ram_arbiter_if m1_if ();
  onchip_ram_arbiter u_dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .err_count(err_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b+:8] <= ram_writedata[8*b+:8];
      ram_readdata <= mem[ram_address];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input int m, input logic rd, input logic w, input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = w; m0_if.address = a; m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = w; m1_if.address = a; m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask
  task automatic idle();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_word(input int m, input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(m, 0, 1, a, d, be);
    tick();
    idle();
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    idle();
    drive(0, 1, 0, 14'h10, '0, 4'hF);
    tick();
    #1;
    check("rst wait0", m0_if.waitrequest, 1);
    check("rst wait1", m1_if.waitrequest, 1);
    check("rst cs", ram_chipselect, 0);
    check("rst clken", ram_clken, 0);
    check("rst err", err_count, 0);
    check("rst rdv0", m0_if.readdatavalid, 0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("clken", ram_clken, 1);
    // 1: write then read-back of the same word on the next cycle
    drive(0, 0, 1, 14'h10, 32'h1234_5678, 4'hF);
    #1;
    check("t1 wait0", m0_if.waitrequest, 0);
    check("t1 cs", ram_chipselect, 1);
    check("t1 we", ram_write, 1);
    check("t1 addr", ram_address, 32'h10);
    tick();
    drive(0, 1, 0, 14'h10, '0, 4'hF);
    check("t1 no rdv on write", m0_if.readdatavalid, 0);
    tick();
    idle();
    check("t1 rdv0", m0_if.readdatavalid, 1);
    check("t1 data0", m0_if.readdata, 32'h1234_5678);
    check("t1 rdv1", m1_if.readdatavalid, 0);
    check("t1 data1", m1_if.readdata, 0);
    // 2: continuous contention alternates grants starting with m0 after reset
    wr_word(0, 14'h20, 32'h0000_00A0, 4'hF);
    wr_word(0, 14'h21, 32'h0000_00B1, 4'hF);
    do_reset();
    drive(0, 1, 0, 14'h20, '0, 4'hF);
    drive(1, 1, 0, 14'h21, '0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2 wait0", m0_if.waitrequest, (i % 2 == 0) ? 0 : 1);
      check("t2 wait1", m1_if.waitrequest, (i % 2 == 0) ? 1 : 0);
      tick();
      check("t2 data0", m0_if.readdata, (i % 2 == 0) ? 32'hA0 : 32'h0);
      check("t2 data1", m1_if.readdata, (i % 2 == 0) ? 32'h0 : 32'hB1);
      check("t2 rdv1", m1_if.readdatavalid, (i % 2 == 0) ? 0 : 1);
    end
    idle();
    // 3: partial byte write merges into the existing word
    wr_word(1, 14'h3, 32'hFFFF_FFFF, 4'hF);
    wr_word(1, 14'h3, 32'hAABB_CCDD, 4'b0010);
    drive(1, 1, 0, 14'h3, '0, 4'hF);
    tick();
    idle();
    check("t3 rdv1", m1_if.readdatavalid, 1);
    check("t3 data1", m1_if.readdata, 32'hFFFF_CCFF);
    // 4: out-of-range read returns the error pattern and the counter saturates
    drive(0, 1, 0, 14'd10240, '0, 4'hF);
    #1;
    check("t4 cs", ram_chipselect, 0);
    check("t4 wait0", m0_if.waitrequest, 0);
    tick();
    idle();
    check("t4 rdv0", m0_if.readdatavalid, 1);
    check("t4 data0", m0_if.readdata, 32'hDEAD_BEEF);
    check("t4 err1", err_count, 1);
    drive(0, 0, 1, 14'h3FFF, 32'h5555_5555, 4'hF);
    #1;
    check("t4 we dropped", ram_write, 0);
    for (int i = 0; i < 300; i++) tick();
    idle();
    check("t4 err sat", err_count, 255);
    check("t4 no rdv on bad write", m0_if.readdatavalid, 0);
    // 5: reset while an m1 read is in flight drops its response
    drive(1, 1, 0, 14'h21, '0, 4'hF);
    tick();
    idle();
    reset = 1'b1;
    #1;
    check("t5 rdv1 in rst", m1_if.readdatavalid, 0);
    tick();
    reset = 1'b0;
    check("t5 rdv1 after", m1_if.readdatavalid, 0);
    check("t5 err", err_count, 0);
    drive(0, 1, 0, 14'h20, '0, 4'hF);
    drive(1, 1, 0, 14'h21, '0, 4'hF);
    #1;
    check("t5 wait0", m0_if.waitrequest, 0);
    check("t5 wait1", m1_if.waitrequest, 1);
    tick();
    idle();
    check("t5 data0", m0_if.readdata, 32'hA0);
    // 6: m0 read races an m1 write to the same word; the read sees the old value
    wr_word(0, 14'h40, 32'h1111_1111, 4'hF);
    do_reset();
    drive(0, 1, 0, 14'h40, '0, 4'hF);
    drive(1, 0, 1, 14'h40, 32'h2222_2222, 4'hF);
    #1;
    check("t6 wait0", m0_if.waitrequest, 0);
    check("t6 wait1", m1_if.waitrequest, 1);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    #1;
    check("t6 old data", m0_if.readdata, 32'h1111_1111);
    check("t6 wait1 next", m1_if.waitrequest, 0);
    check("t6 we", ram_write, 1);
    tick();
    idle();
    drive(0, 1, 0, 14'h40, '0, 4'hF);
    tick();
    idle();
    check("t6 new data", m0_if.readdata, 32'h2222_2222);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
